// File: rtl/xpb_pkg.sv
// rtl/xpb_pkg.sv - shared constants, FSM states and table-entry type for the XPB table generator
// Contents:
//   DATA_W, DIGIT_W, LIMB_W, NUM_LIMBS, NUM_ENTRIES, LIMB_IDX_W
//   gen_state_t  : IDLE, WRITE, ADD, DONE
//   xpb_entry_t  : {addr, data} pair as seen by the lookup side
package xpb_pkg;

  localparam int DATA_W      = 1024;
  localparam int DIGIT_W     = 5;
  localparam int LIMB_W      = 64;
  localparam int NUM_LIMBS   = DATA_W / LIMB_W;
  localparam int NUM_ENTRIES = 1 << DIGIT_W;
  localparam int LIMB_IDX_W  = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } gen_state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] addr;
    logic [DATA_W-1:0]  data;
  } xpb_entry_t;

endpackage

// File: rtl/xpb_limb_addsub.sv
// rtl/xpb_limb_addsub.sv - one limb of the serial add-then-subtract step
// Ports:
//   a, b   in  LIMB_W  accumulator limb and base limb
//   n      in  LIMB_W  modulus limb
//   cin    in  1       sum carry from the previous limb
//   bin    in  1       subtract borrow from the previous limb
//   s      out LIMB_W  a + b + cin
//   d      out LIMB_W  s - n - bin
//   cout   out 1       carry out of the sum
//   bout   out 1       borrow out of the difference
module xpb_limb_addsub
  import xpb_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic [LIMB_W-1:0] n,
  input  logic              cin,
  input  logic              bin,
  output logic [LIMB_W-1:0] s,
  output logic [LIMB_W-1:0] d,
  output logic              cout,
  output logic              bout
);

  logic [LIMB_W:0] sum_w;
  logic [LIMB_W:0] dif_w;

  always_comb begin
    sum_w = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
    // The difference is taken on the truncated sum; the sum carry is
    // resolved by the caller when choosing between s and d.
    dif_w = {1'b0, sum_w[LIMB_W-1:0]} - {1'b0, n} - {{LIMB_W{1'b0}}, bin};
    s     = sum_w[LIMB_W-1:0];
    cout  = sum_w[LIMB_W];
    d     = dif_w[LIMB_W-1:0];
    bout  = dif_w[LIMB_W];
  end

endmodule

// File: rtl/xpb_table_gen.sv
// rtl/xpb_table_gen.sv - streams entry[j] = (j*B) mod N into the XPB table RAM
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, honoured only in IDLE
//   modulus, base       N and B, captured on an accepted start
//   busy                high from accepted start until DONE is left
//   done                one-cycle pulse after the last entry is accepted
//   wr_valid, wr_ready  table write handshake
//   wr_addr, wr_data    entry index j and (j*B) mod N
module xpb_table_gen
  import xpb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DATA_W-1:0]  modulus,
  input  logic [DATA_W-1:0]  base,
  output logic               busy,
  output logic               done,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [DIGIT_W-1:0] wr_addr,
  output logic [DATA_W-1:0]  wr_data
);

  gen_state_t state, state_nxt;

  logic [DATA_W-1:0]     mod_q;
  logic [DATA_W-1:0]     base_q;
  logic [DATA_W-1:0]     acc;
  logic [DATA_W-1:0]     s_buf;
  logic [DATA_W-1:0]     d_buf;
  logic [DIGIT_W-1:0]    j_cnt;
  logic [LIMB_IDX_W-1:0] limb;
  logic                  carry;
  logic                  borrow;

  logic [LIMB_W-1:0]     s_k;
  logic [LIMB_W-1:0]     d_k;
  logic                  c_k;
  logic                  b_k;
  logic                  last_j;
  logic                  last_limb;

  assign last_j    = (j_cnt == DIGIT_W'(NUM_ENTRIES - 1));
  assign last_limb = (limb == LIMB_IDX_W'(NUM_LIMBS - 1));

  // Operand registers rotate right by one limb per ADD cycle, so the
  // active limb is always the low limb; after NUM_LIMBS cycles they are
  // back in their original alignment.
  xpb_limb_addsub u_addsub (
    .a    (acc[LIMB_W-1:0]),
    .b    (base_q[LIMB_W-1:0]),
    .n    (mod_q[LIMB_W-1:0]),
    .cin  (carry),
    .bin  (borrow),
    .s    (s_k),
    .d    (d_k),
    .cout (c_k),
    .bout (b_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = WRITE;
      WRITE: if (wr_ready) state_nxt = last_j ? DONE : ADD;
      ADD:   if (last_limb) state_nxt = WRITE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_q  <= '0;
      base_q <= '0;
      acc    <= '0;
      s_buf  <= '0;
      d_buf  <= '0;
      j_cnt  <= '0;
      limb   <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mod_q  <= modulus;
            base_q <= base;
            acc    <= '0;
            j_cnt  <= '0;
          end
        end
        WRITE: begin
          if (wr_ready && !last_j) begin
            j_cnt  <= j_cnt + 1'b1;
            limb   <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
          end
        end
        ADD: begin
          limb   <= limb + 1'b1;
          carry  <= c_k;
          borrow <= b_k;
          mod_q  <= {mod_q[LIMB_W-1:0], mod_q[DATA_W-1:LIMB_W]};
          base_q <= {base_q[LIMB_W-1:0], base_q[DATA_W-1:LIMB_W]};
          s_buf  <= {s_k, s_buf[DATA_W-1:LIMB_W]};
          d_buf  <= {d_k, d_buf[DATA_W-1:LIMB_W]};
          if (last_limb) begin
            // s >= N exactly when the sum overflowed DATA_W bits or the
            // subtraction did not borrow; then the reduced value is d.
            if (c_k || !b_k) acc <= {d_k, d_buf[DATA_W-1:LIMB_W]};
            else             acc <= {s_k, s_buf[DATA_W-1:LIMB_W]};
          end else begin
            acc <= {acc[LIMB_W-1:0], acc[DATA_W-1:LIMB_W]};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign wr_valid = (state == WRITE);
  assign wr_addr  = j_cnt;
  assign wr_data  = acc;

endmodule

// File: tb/tb_xpb_table_gen.sv
// tb/tb_xpb_table_gen.sv - scoreboard bench for xpb_table_gen
module tb_xpb_table_gen;
  import xpb_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [DATA_W-1:0]  modulus;
  logic [DATA_W-1:0]  base;
  logic               busy;
  logic               done;
  logic               wr_valid;
  logic               wr_ready;
  logic [DIGIT_W-1:0] wr_addr;
  logic [DATA_W-1:0]  wr_data;

  int         tests = 0;
  int         fails = 0;
  xpb_entry_t exp_q[$];
  int         done_cnt = 0;
  int         acc_cnt = 0;
  bit         bp_mode = 1'b0;

  bit                 stalled = 1'b0;
  logic [DIGIT_W-1:0] s_addr;
  logic [DATA_W-1:0]  s_data;

  xpb_table_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .modulus  (modulus),
    .base     (base),
    .busy     (busy),
    .done     (done),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      wr_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_wide();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Golden entry: plain wide multiply and modulo.
  function automatic logic [DATA_W-1:0] ref_entry(input int j, input logic [DATA_W-1:0] n,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W+DIGIT_W-1:0] p;
    logic [DATA_W+DIGIT_W-1:0] nn;
    p  = {{DIGIT_W{1'b0}}, b};
    p  = p * (DATA_W+DIGIT_W)'(j);
    nn = {{DIGIT_W{1'b0}}, n};
    p  = p % nn;
    return p[DATA_W-1:0];
  endfunction

  // Monitor: pops one expected entry per accepted write; checks hold during stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (stalled) begin
        check("stall_addr", DATA_W'(wr_addr), DATA_W'(s_addr));
        check("stall_data", wr_data, s_data);
      end
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0d want no write", wr_addr);
        end else begin
          xpb_entry_t e;
          e = exp_q.pop_front();
          check("wr_addr", DATA_W'(wr_addr), DATA_W'(e.addr));
          check("wr_data", wr_data, e.data);
        end
        acc_cnt++;
      end
      stalled = wr_valid && !wr_ready;
      s_addr  = wr_addr;
      s_data  = wr_data;
    end
  end

  task automatic start_run(input logic [DATA_W-1:0] n, input logic [DATA_W-1:0] b);
    for (int j = 0; j < NUM_ENTRIES; j++) begin
      xpb_entry_t e;
      e.addr = DIGIT_W'(j);
      e.data = ref_entry(j, n, b);
      exp_q.push_back(e);
    end
    done_cnt = 0;
    acc_cnt  = 0;
    @(negedge clk);
    modulus = n;
    base    = b;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic run_table(input logic [DATA_W-1:0] n, input logic [DATA_W-1:0] b,
                           input bit bp, input bit intrude, input bit chk_lat);
    int cyc;
    bp_mode = bp;
    start_run(n, b);
    cyc = 1;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (intrude && cyc == 100) begin
        modulus = rand_wide();
        base    = rand_wide();
        start   = 1'b1;
      end
      if (intrude && cyc == 101) start = 1'b0;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles want done", cyc);
    end
    if (chk_lat) check("done_latency", DATA_W'(cyc), DATA_W'(529));
    repeat (3) @(negedge clk);
    check("done_pulses", DATA_W'(done_cnt), DATA_W'(1));
    check("queue_drained", DATA_W'(exp_q.size()), '0);
    check("busy_after_done", DATA_W'(busy), '0);
    exp_q.delete();
    bp_mode = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] n;
    logic [DATA_W-1:0] b;
    int                guard;

    rst_n   = 1'b0;
    start   = 1'b0;
    modulus = '0;
    base    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", DATA_W'(busy), '0);
    check("rst_done", DATA_W'(done), '0);
    check("rst_wr_valid", DATA_W'(wr_valid), '0);
    check("rst_wr_addr", DATA_W'(wr_addr), '0);
    check("rst_wr_data", wr_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity table: N all ones, B = 1.
    run_table({DATA_W{1'b1}}, DATA_W'(1), 1'b0, 1'b0, 1'b1);

    // Maximum base: B = N - 1 with odd full-width N.
    n = rand_wide();
    n[0] = 1'b1;
    n[DATA_W-1] = 1'b1;
    run_table(n, n - 1'b1, 1'b0, 1'b0, 1'b1);

    // Random pairs, B < N.
    for (int k = 0; k < 20; k++) begin
      n = rand_wide();
      if (k % 4 == 1) n = n >> $urandom_range(1, 900);
      if (n < 2) n = DATA_W'(3);
      b = rand_wide() % n;
      run_table(n, b, 1'b0, 1'b0, 1'b1);
    end

    // Backpressure with ready high about 30% of cycles.
    for (int k = 0; k < 3; k++) begin
      n = rand_wide();
      n[DATA_W-1] = 1'b1;
      b = rand_wide() % n;
      run_table(n, b, 1'b1, 1'b0, 1'b0);
    end

    // Start while busy is ignored.
    n = rand_wide();
    n[DATA_W-1] = 1'b1;
    b = rand_wide() % n;
    run_table(n, b, 1'b0, 1'b1, 1'b1);

    // Reset during the ADD that follows entry 6.
    n = rand_wide();
    n[DATA_W-1] = 1'b1;
    b = rand_wide() % n;
    start_run(n, b);
    guard = 0;
    while (acc_cnt < 7 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (acc_cnt < 7) begin
      tests++;
      fails++;
      $display("FAIL abort_wait: got %0d writes want 7", acc_cnt);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_wr_valid", DATA_W'(wr_valid), '0);
    check("abort_busy", DATA_W'(busy), '0);
    check("abort_done", DATA_W'(done), '0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n = rand_wide();
    n[0] = 1'b1;
    b = rand_wide() % n;
    run_table(n, b, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
